hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight producers after D, raises
// stall on unmet Tuse/Tnew or busy mul/div, and picks forwarding sources.
module hazard_scoreboard #(
    parameter int NREG_W   = 5,
    parameter int STAGES   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           d_valid,
    input  logic [NREG_W-1:0]              d_rs,
    input  logic [NREG_W-1:0]              d_rt,
    input  logic [2:0]                     d_tuse_rs,
    input  logic [2:0]                     d_tuse_rt,
    input  logic                           d_wr_en,
    input  logic [NREG_W-1:0]              d_wr_reg,
    input  logic [TNEW_W-1:0]              d_tnew,
    input  logic                           d_md,
    input  logic                           d_md_start,
    input  logic                           d_md_div,
    input  logic                           flush,
    output logic                           stall,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rs_sel,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rt_sel,
    output logic                           md_busy,
    output logic [15:0]                    stall_count
);
    localparam int SEL_W  = $clog2(STAGES + 1);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    // Stage k = 1 is E; higher k are older producers.
    logic              stg_valid  [1:STAGES];
    logic              stg_wr_en  [1:STAGES];
    logic [NREG_W-1:0] stg_wr_reg [1:STAGES];
    logic [TNEW_W-1:0] stg_tnew   [1:STAGES];

    logic [MD_W-1:0]   md_cnt;

    logic              rs_hit, rt_hit;
    logic [SEL_W-1:0]  rs_k, rt_k;
    logic [TNEW_W-1:0] rs_tnew, rt_tnew;
    logic              rs_stall, rt_stall, md_stall, accept;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        rs_hit  = 1'b0;
        rs_k    = '0;
        rs_tnew = '0;
        rt_hit  = 1'b0;
        rt_k    = '0;
        rt_tnew = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (stg_valid[k] && stg_wr_en[k] && stg_wr_reg[k] == d_rs &&
                d_rs != '0 && d_tuse_rs != 3'd7) begin
                rs_hit  = 1'b1;
                rs_k    = SEL_W'(k);
                rs_tnew = stg_tnew[k];
            end
            if (stg_valid[k] && stg_wr_en[k] && stg_wr_reg[k] == d_rt &&
                d_rt != '0 && d_tuse_rt != 3'd7) begin
                rt_hit  = 1'b1;
                rt_k    = SEL_W'(k);
                rt_tnew = stg_tnew[k];
            end
        end
    end

    always_comb begin
        md_busy    = (md_cnt != '0);
        rs_stall   = rs_hit && (int'(d_tuse_rs) < int'(rs_tnew));
        rt_stall   = rt_hit && (int'(d_tuse_rt) < int'(rt_tnew));
        md_stall   = d_md && md_busy;
        stall      = d_valid && !flush && (rs_stall || rt_stall || md_stall);
        accept     = d_valid && !stall && !flush;
        fwd_rs_sel = (d_valid && rs_hit && rs_tnew == '0) ? rs_k : '0;
        fwd_rt_sel = (d_valid && rt_hit && rt_tnew == '0) ? rt_k : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                stg_valid[k]  <= 1'b0;
                stg_wr_en[k]  <= 1'b0;
                stg_wr_reg[k] <= '0;
                stg_tnew[k]   <= '0;
            end
            md_cnt      <= '0;
            stall_count <= '0;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                stg_valid[k]  <= stg_valid[k-1] && !flush;
                stg_wr_en[k]  <= stg_wr_en[k-1];
                stg_wr_reg[k] <= stg_wr_reg[k-1];
                stg_tnew[k]   <= (stg_tnew[k-1] == '0) ? '0 : stg_tnew[k-1] - TNEW_W'(1);
            end
            stg_valid[1]  <= accept;
            stg_wr_en[1]  <= d_wr_en;
            stg_wr_reg[1] <= d_wr_reg;
            stg_tnew[1]   <= d_tnew;

            // Flush leaves an in-flight mul/div running; only reset clears it.
            if (accept && d_md_start)
                md_cnt <= d_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
            else if (md_busy)
                md_cnt <= md_cnt - MD_W'(1);

            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each cycle's expected outputs are
// queued when stimulus is applied and checked on the falling edge.
module tb_hazard_scoreboard;
    localparam int NREG_W = 5;
    localparam int STAGES = 3;
    localparam int TNEW_W = 2;
    localparam int SEL_W  = $clog2(STAGES + 1);
    localparam int EXP_W  = 1 + SEL_W + SEL_W + 1 + 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_valid;
    logic [NREG_W-1:0] d_rs, d_rt, d_wr_reg;
    logic [2:0]        d_tuse_rs, d_tuse_rt;
    logic              d_wr_en;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_md, d_md_start, d_md_div, flush;
    logic              stall, md_busy;
    logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [15:0]       stall_count;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];
    string            tag_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG_W(NREG_W), .STAGES(STAGES), .TNEW_W(TNEW_W),
        .MULT_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_en(d_wr_en), .d_wr_reg(d_wr_reg), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy), .stall_count(stall_count)
    );

    task automatic clear_d();
        d_valid = 1'b0; d_rs = '0; d_rt = '0;
        d_tuse_rs = 3'd7; d_tuse_rt = 3'd7;
        d_wr_en = 1'b0; d_wr_reg = '0; d_tnew = '0;
        d_md = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0; flush = 1'b0;
    endtask

    task automatic producer(input logic [NREG_W-1:0] r, input logic [TNEW_W-1:0] t);
        clear_d();
        d_valid = 1'b1; d_wr_en = 1'b1; d_wr_reg = r; d_tnew = t;
    endtask

    task automatic consumer_rs(input logic [NREG_W-1:0] r, input logic [2:0] tu);
        clear_d();
        d_valid = 1'b1; d_rs = r; d_tuse_rs = tu;
    endtask

    // Queue expectation, compare on the falling edge, advance past the next rising edge.
    task automatic check(input string tag, input logic s, input logic [SEL_W-1:0] rs,
                         input logic [SEL_W-1:0] rt, input logic b, input logic [15:0] cnt);
        logic [EXP_W-1:0] exp_v, obs_v;
        string t;
        exp_q.push_back({s, rs, rt, b, cnt});
        tag_q.push_back(tag);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {stall, fwd_rs_sel, fwd_rt_sel, md_busy, stall_count};
        test_cnt++;
        assert (obs_v === exp_v) else begin
            fail_cnt++;
            $error("FAIL %s: observed {stall,rs,rt,busy,cnt}=%b/%0d/%0d/%b/%0d expected %b/%0d/%0d/%b/%0d",
                   t, obs_v[EXP_W-1], obs_v[EXP_W-2 -: SEL_W], obs_v[EXP_W-2-SEL_W -: SEL_W],
                   obs_v[16], obs_v[15:0], exp_v[EXP_W-1], exp_v[EXP_W-2 -: SEL_W],
                   exp_v[EXP_W-2-SEL_W -: SEL_W], exp_v[16], exp_v[15:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input logic b, input logic [15:0] cnt);
        clear_d();
        for (int i = 0; i < STAGES; i++) check(tag, 1'b0, '0, '0, b, cnt);
    endtask

    initial begin
        clear_d();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", 1'b0, '0, '0, 1'b0, 16'd0);

        // Load-use: load $8 Tnew=2, dependent rs=$8 Tuse=1.
        producer(5'd8, 2'd2);
        check("lu_load", 1'b0, '0, '0, 1'b0, 16'd0);
        consumer_rs(5'd8, 3'd1);
        check("lu_stall", 1'b1, '0, '0, 1'b0, 16'd0);
        check("lu_release", 1'b0, '0, '0, 1'b0, 16'd1);
        consumer_rs(5'd8, 3'd0);
        check("lu_fwd_w", 1'b0, 2'd3, '0, 1'b0, 16'd1);
        drain("lu_drain", 1'b0, 16'd1);

        // ALU result needed in D: one stall then forward from M.
        producer(5'd9, 2'd1);
        check("alu_add", 1'b0, '0, '0, 1'b0, 16'd1);
        consumer_rs(5'd9, 3'd0);
        check("alu_beq_stall", 1'b1, '0, '0, 1'b0, 16'd1);
        check("alu_beq_fwd_m", 1'b0, 2'd2, '0, 1'b0, 16'd2);
        drain("alu_drain1", 1'b0, 16'd2);

        // ALU result needed in E: no stall, forwarded once the consumer moves on.
        producer(5'd9, 2'd1);
        check("alu2_add", 1'b0, '0, '0, 1'b0, 16'd2);
        consumer_rs(5'd9, 3'd1);
        check("alu2_tuse1", 1'b0, '0, '0, 1'b0, 16'd2);
        consumer_rs(5'd9, 3'd1);
        check("alu2_next_fwd_m", 1'b0, 2'd2, '0, 1'b0, 16'd2);
        drain("alu2_drain", 1'b0, 16'd2);

        // Youngest wins: $5 in stages 1 and 2.
        producer(5'd5, 2'd0);
        check("yw_first", 1'b0, '0, '0, 1'b0, 16'd2);
        producer(5'd5, 2'd0);
        d_rt = 5'd5; d_tuse_rt = 3'd0;
        check("yw_second_reads", 1'b0, '0, 2'd1, 1'b0, 16'd2);
        clear_d();
        d_valid = 1'b1; d_rt = 5'd5; d_tuse_rt = 3'd0;
        check("yw_youngest", 1'b0, '0, 2'd1, 1'b0, 16'd2);
        drain("yw_drain", 1'b0, 16'd2);

        // $0 destination never creates a hazard.
        producer(5'd0, 2'd2);
        check("r0_write", 1'b0, '0, '0, 1'b0, 16'd2);
        clear_d();
        d_valid = 1'b1; d_tuse_rs = 3'd0; d_tuse_rt = 3'd0;
        check("r0_read", 1'b0, '0, '0, 1'b0, 16'd2);
        drain("r0_drain", 1'b0, 16'd2);

        // Divide then mflo: exactly 10 stall cycles.
        clear_d();
        d_valid = 1'b1; d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
        check("div_start", 1'b0, '0, '0, 1'b0, 16'd2);
        clear_d();
        d_valid = 1'b1; d_md = 1'b1;
        for (int i = 0; i < 10; i++) check("div_mflo_stall", 1'b1, '0, '0, 1'b1, 16'(2 + i));
        check("div_done", 1'b0, '0, '0, 1'b0, 16'd12);
        drain("div_drain", 1'b0, 16'd12);

        // Flush with a load in E and its dependent in D; mul counter keeps running.
        clear_d();
        d_valid = 1'b1; d_md = 1'b1; d_md_start = 1'b1;
        check("fl_mul_start", 1'b0, '0, '0, 1'b0, 16'd12);
        producer(5'd8, 2'd2);
        check("fl_load", 1'b0, '0, '0, 1'b1, 16'd12);
        consumer_rs(5'd8, 3'd1);
        flush = 1'b1;
        check("fl_flush", 1'b0, '0, '0, 1'b1, 16'd12);
        consumer_rs(5'd8, 3'd0);
        check("fl_stages_empty", 1'b0, '0, '0, 1'b1, 16'd12);
        clear_d();
        check("fl_md_cnt2", 1'b0, '0, '0, 1'b1, 16'd12);
        check("fl_md_cnt1", 1'b0, '0, '0, 1'b1, 16'd12);
        check("fl_md_done", 1'b0, '0, '0, 1'b0, 16'd12);

        // Reset in the middle of a divide while stalled.
        clear_d();
        d_valid = 1'b1; d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
        check("rst_div_start", 1'b0, '0, '0, 1'b0, 16'd12);
        clear_d();
        d_valid = 1'b1; d_md = 1'b1;
        for (int i = 0; i < 6; i++) check("rst_mflo_stall", 1'b1, '0, '0, 1'b1, 16'(12 + i));
        reset = 1'b1;
        check("rst_asserted", 1'b1, '0, '0, 1'b1, 16'd18);
        reset = 1'b0;
        check("rst_cleared", 1'b0, '0, '0, 1'b0, 16'd0);
        clear_d();
        check("rst_idle", 1'b0, '0, '0, 1'b0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
